// File: rtl/prm_chk_pkg.sv
// Shared types and default sizing for the PRM checker-bank scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package prm_chk_pkg;

    localparam int CFG_W_DEF   = 15;
    localparam int N_EDGE_DEF  = 1024;
    localparam int CHK_LAT_DEF = 2;
    localparam int CNT_W_DEF   = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        RESULT
    } state_t;

    typedef logic [CFG_W_DEF-1:0] cfg_t;

endpackage

// File: rtl/prm_chk_tag_pipe.sv
// In-flight tag pipe mirroring the checker bank delay; optional index tags (PRM_CHK_FIRST_HIT_EN).
// Latency: LAT cycles from in_vld to out_vld; LAT=0 is a pure pass-through.
// Backpressure: none, shifts every cycle; empty/empty_nxt report occupancy now and after this edge.
module prm_chk_tag_pipe #(
    parameter int LAT = 2
`ifdef PRM_CHK_FIRST_HIT_EN
    ,
    parameter int IDX_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
`ifdef PRM_CHK_FIRST_HIT_EN
    input  logic [IDX_W-1:0] in_idx,
    output logic [IDX_W-1:0] out_idx,
`endif
    output logic             out_vld,
    output logic             empty,
    output logic             empty_nxt
);

    generate
        if (LAT == 0) begin : g_pass
            assign out_vld   = in_vld;
            assign empty     = 1'b1;
            assign empty_nxt = 1'b1;
`ifdef PRM_CHK_FIRST_HIT_EN
            assign out_idx   = in_idx;
`endif
        end else begin : g_pipe
            logic [LAT-1:0] v;

            // Valid tags advance one stage per cycle; reset discards everything in flight.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v <= '0;
                end else begin
                    v[0] <= in_vld;
                    for (int i = 1; i < LAT; i++) v[i] <= v[i-1];
                end
            end

            assign out_vld = v[LAT-1];
            assign empty   = (v == '0);

            // Pipe is empty after this edge when nothing enters and only the exiting stage is occupied.
            always_comb begin
                empty_nxt = !in_vld;
                for (int i = 0; i < LAT - 1; i++) begin
                    if (v[i]) empty_nxt = 1'b0;
                end
            end

`ifdef PRM_CHK_FIRST_HIT_EN
            logic [IDX_W-1:0] ix [LAT];

            // Index tags shadow the valid tags stage for stage.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < LAT; i++) ix[i] <= '0;
                end else begin
                    ix[0] <= in_idx;
                    for (int i = 1; i < LAT; i++) ix[i] <= ix[i-1];
                end
            end

            assign out_idx = ix[LAT-1];
`endif
        end
    endgenerate

endmodule

// File: rtl/prm_chk_batch_sched.sv
// Issues batched configuration codes to the PRM checker bank and OR-accumulates masks; PRM_CHK_FIRST_HIT_EN adds first-hit reporting.
// Latency: chk_vld same cycle as accept; res_valid CHK_LAT+1 cycles after the last accept.
// Backpressure: cmd_ready low in DRAIN/RESULT; result held until res_ready.
module prm_chk_batch_sched
    import prm_chk_pkg::*;
#(
    parameter int CFG_W   = CFG_W_DEF,
    parameter int N_EDGE  = N_EDGE_DEF,
    parameter int CHK_LAT = CHK_LAT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CFG_W-1:0]  cmd_cfg,
    input  logic              cmd_last,
    output logic              chk_vld,
    output logic [CFG_W-1:0]  chk_cfg,
    input  logic [N_EDGE-1:0] chk_mask,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [N_EDGE-1:0] res_blocked,
    output logic [CNT_W-1:0]  res_count,
`ifdef PRM_CHK_FIRST_HIT_EN
    output logic [CNT_W-1:0]  res_first_hit,
    output logic              res_hit,
`endif
    output logic              busy
);

    state_t state, state_nxt;
    logic   acc;
    logic   res_fire;
    logic   exit_vld;
    logic   pipe_empty;
    logic   pipe_empty_nxt;

    assign acc      = cmd_valid & cmd_ready;
    assign res_fire = res_valid & res_ready;
    assign chk_vld  = acc;
    assign chk_cfg  = acc ? cmd_cfg : '0;
    assign busy     = (state != IDLE) || !pipe_empty;

`ifdef PRM_CHK_FIRST_HIT_EN
    logic [CNT_W-1:0] exit_idx;

    prm_chk_tag_pipe #(.LAT(CHK_LAT), .IDX_W(CNT_W)) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_vld    (acc),
        .in_idx    (res_count),
        .out_idx   (exit_idx),
        .out_vld   (exit_vld),
        .empty     (pipe_empty),
        .empty_nxt (pipe_empty_nxt)
    );
`else
    prm_chk_tag_pipe #(.LAT(CHK_LAT)) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_vld    (acc),
        .out_vld   (exit_vld),
        .empty     (pipe_empty),
        .empty_nxt (pipe_empty_nxt)
    );
`endif

    // Batch state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state: last accept goes to DRAIN, or straight to RESULT when the bank has no delay.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, ISSUE: begin
                if (acc) begin
                    if (!cmd_last)         state_nxt = ISSUE;
                    else if (CHK_LAT == 0) state_nxt = RESULT;
                    else                   state_nxt = DRAIN;
                end
            end
            DRAIN:   if (pipe_empty_nxt) state_nxt = RESULT;
            RESULT:  if (res_fire)       state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs; cmd_ready is also forced low while reset is held.
    always_comb begin
        cmd_ready = !rst && ((state == IDLE) || (state == ISSUE));
        res_valid = (state == RESULT);
    end

    // Accumulate retiring masks and count accepts; clear once the result is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_blocked <= '0;
            res_count   <= '0;
        end else if (res_fire) begin
            res_blocked <= '0;
            res_count   <= '0;
        end else begin
            if (exit_vld) res_blocked <= res_blocked | chk_mask;
            if (acc && (res_count != {CNT_W{1'b1}})) res_count <= res_count + 1'b1;
        end
    end

`ifdef PRM_CHK_FIRST_HIT_EN
    // Latch the index of the first retiring code whose mask has any bit set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_hit       <= 1'b0;
            res_first_hit <= '0;
        end else if (res_fire) begin
            res_hit       <= 1'b0;
            res_first_hit <= '0;
        end else if (exit_vld && (|chk_mask) && !res_hit) begin
            res_hit       <= 1'b1;
            res_first_hit <= exit_idx;
        end
    end
`endif

endmodule

// File: tb/tb_prm_chk_batch_sched.sv
// Directed self-checking bench for prm_chk_batch_sched with a 2-cycle bank model.
// Latency: bank model returns the issued mask 2 cycles after chk_vld, junk otherwise.
// Backpressure: res_ready driven explicitly per scenario.
module tb_prm_chk_batch_sched;

    localparam int CFG_W  = 15;
    localparam int N_EDGE = 1024;
    localparam int LAT    = 2;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [CFG_W-1:0]  cmd_cfg;
    logic              cmd_last;
    logic              chk_vld;
    logic [CFG_W-1:0]  chk_cfg;
    logic [N_EDGE-1:0] chk_mask;
    logic              res_valid;
    logic              res_ready;
    logic [N_EDGE-1:0] res_blocked;
    logic [CNT_W-1:0]  res_count;
    logic              busy;
`ifdef PRM_CHK_FIRST_HIT_EN
    logic [CNT_W-1:0]  res_first_hit;
    logic              res_hit;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    prm_chk_batch_sched #(
        .CFG_W(CFG_W), .N_EDGE(N_EDGE), .CHK_LAT(LAT), .CNT_W(CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_cfg       (cmd_cfg),
        .cmd_last      (cmd_last),
        .chk_vld       (chk_vld),
        .chk_cfg       (chk_cfg),
        .chk_mask      (chk_mask),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_blocked   (res_blocked),
        .res_count     (res_count),
`ifdef PRM_CHK_FIRST_HIT_EN
        .res_first_hit (res_first_hit),
        .res_hit       (res_hit),
`endif
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Bank model: mask chosen by the stimulus for the code issued, returned 2 cycles later.
    logic [N_EDGE-1:0] cur_mask;
    logic [N_EDGE-1:0] bm0, bm1;
    logic [1:0]        bv = 2'b00;
    logic [N_EDGE-1:0] junk;
    assign junk = {1'b1, {(N_EDGE-1){1'b0}}};

    always @(posedge clk) begin
        bv  <= {bv[0], chk_vld};
        bm0 <= cur_mask;
        bm1 <= bm0;
    end
    assign chk_mask = bv[1] ? bm1 : junk;

    function automatic logic [N_EDGE-1:0] bit_m(input int b);
        logic [N_EDGE-1:0] m;
        m    = '0;
        m[b] = 1'b1;
        return m;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic wait_res(output int cyc);
        cyc = 1;
        while (!res_valid && cyc < 20) begin
            step;
            cyc++;
        end
    endtask

    task automatic pop_res;
        res_ready = 1'b1;
        step;
        res_ready = 1'b0;
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        logic bad;
        logic [N_EDGE-1:0] exp_v;

        rst = 1'b1; cmd_valid = 1'b1; cmd_cfg = 15'h1234; cmd_last = 1'b0;
        res_ready = 1'b0; cur_mask = '0;

        // Reset state, with a code pending that must not be issued.
        step;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_chk_vld", chk_vld, 0);
        check("rst_chk_cfg", chk_cfg, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_blocked", $countones(res_blocked), 0);
        check("rst_count", res_count, 0);
        check("rst_busy", busy, 0);
        cmd_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("idle_ready", cmd_ready, 1);

        // Single code, mask bit 783.
        step;
        cmd_valid = 1'b1; cmd_cfg = 15'h4C21; cmd_last = 1'b1; cur_mask = bit_m(783);
        #1;
        check("t1_chk_vld", chk_vld, 1);
        check("t1_chk_cfg", chk_cfg, 15'h4C21);
        step;
        cmd_valid = 1'b0; cmd_last = 1'b0; cur_mask = '0;
        #1;
        check("t1_cfg_zero", chk_cfg, 0);
        check("t1_busy", busy, 1);
        check("t1_drain_rdy", cmd_ready, 0);
        wait_res(cyc);
        check("t1_latency", cyc, 3);
        check("t1_bit783", res_blocked[783], 1);
        check("t1_popcnt", $countones(res_blocked), 1);
        check("t1_count", res_count, 1);
        pop_res;
        check("t1_after_valid", res_valid, 0);
        check("t1_after_count", res_count, 0);
        check("t1_after_blk", $countones(res_blocked), 0);
        check("t1_after_busy", busy, 0);

        // Four back-to-back codes with masks 1,2,4,0.
        for (int i = 0; i < 4; i++) begin
            step;
            cmd_valid = 1'b1; cmd_cfg = CFG_W'(i + 1); cmd_last = (i == 3);
            cur_mask = (i < 3) ? bit_m(i) : '0;
            #1;
            check("t2_chk_vld", chk_vld, 1);
        end
        step;
        cmd_valid = 1'b0; cmd_last = 1'b0; cur_mask = '0;
        wait_res(cyc);
        exp_v = bit_m(0) | bit_m(1) | bit_m(2);
        check("t2_latency", cyc, 3);
        check("t2_blk_lo", res_blocked[63:0], 64'h7);
        check("t2_blk_eq", res_blocked == exp_v, 1);
        check("t2_count", res_count, 4);

        // Result backpressure with a new code pending.
        step;
        cmd_valid = 1'b1; cmd_cfg = 15'h0111; cmd_last = 1'b1; cur_mask = bit_m(5);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (cmd_ready !== 1'b0 || chk_vld !== 1'b0 || res_valid !== 1'b1 ||
                res_count !== 16'd4 || res_blocked !== exp_v) bad = 1'b1;
            step;
        end
        check("bp_stable", bad, 0);
        res_ready = 1'b1;
        #1;
        check("bp_hs_rdy", cmd_ready, 0);
        step;
        res_ready = 1'b0;
        #1;
        check("bp_idle_rdy", cmd_ready, 1);
        check("bp_accept", chk_vld, 1);
        check("bp_valid_lo", res_valid, 0);
        step;
        cmd_valid = 1'b0; cmd_last = 1'b0; cur_mask = '0;
        wait_res(cyc);
        check("bp_latency", cyc, 3);
        check("bp_count", res_count, 1);
        check("bp_blk_lo", res_blocked[63:0], 64'h20);
        check("bp_blk_eq", res_blocked == bit_m(5), 1);
        pop_res;

        // Gapped batch: valid 1,0,0,1(last).
        step;
        cmd_valid = 1'b1; cmd_cfg = 15'h0AAA; cmd_last = 1'b0; cur_mask = bit_m(10);
        #1;
        check("g_vld0", chk_vld, 1);
        step;
        cmd_valid = 1'b0; cur_mask = '0;
        #1;
        check("g_rdy1", cmd_ready, 1);
        check("g_res1", res_valid, 0);
        step;
        check("g_rdy2", cmd_ready, 1);
        check("g_busy2", busy, 1);
        step;
        cmd_valid = 1'b1; cmd_cfg = 15'h0555; cmd_last = 1'b1; cur_mask = bit_m(900);
        #1;
        check("g_vld3", chk_vld, 1);
        step;
        cmd_valid = 1'b0; cmd_last = 1'b0; cur_mask = '0;
        wait_res(cyc);
        check("g_latency", cyc, 3);
        check("g_count", res_count, 2);
        check("g_bit10", res_blocked[10], 1);
        check("g_bit900", res_blocked[900], 1);
        check("g_popcnt", $countones(res_blocked), 2);
        pop_res;

        // Reset during DRAIN with a tag in flight.
        step;
        cmd_valid = 1'b1; cmd_cfg = 15'h0007; cmd_last = 1'b1; cur_mask = bit_m(50);
        step;
        cmd_valid = 1'b0; cmd_last = 1'b0; cur_mask = '0;
        #1;
        check("r_busy_pre", busy, 1);
        check("r_count_pre", res_count, 1);
        rst = 1'b1;
        #1;
        check("r_cmd_ready", cmd_ready, 0);
        check("r_res_valid", res_valid, 0);
        check("r_busy", busy, 0);
        check("r_count", res_count, 0);
        step;
        rst = 1'b0;
        step;
        step;
        check("r_late_blk", $countones(res_blocked), 0);
        check("r_late_valid", res_valid, 0);
        check("r_late_busy", busy, 0);
        step;
        cmd_valid = 1'b1; cmd_cfg = 15'h0009; cmd_last = 1'b1; cur_mask = bit_m(60);
        step;
        cmd_valid = 1'b0; cmd_last = 1'b0; cur_mask = '0;
        wait_res(cyc);
        check("r_next_lat", cyc, 3);
        check("r_next_bit60", res_blocked[60], 1);
        check("r_next_pop", $countones(res_blocked), 1);
        check("r_next_count", res_count, 1);
        pop_res;

`ifdef PRM_CHK_FIRST_HIT_EN
        // Five codes, only code 3 hits.
        for (int i = 0; i < 5; i++) begin
            step;
            cmd_valid = 1'b1; cmd_cfg = CFG_W'(16 + i); cmd_last = (i == 4);
            cur_mask = (i == 3) ? bit_m(7) : '0;
        end
        step;
        cmd_valid = 1'b0; cmd_last = 1'b0; cur_mask = '0;
        wait_res(cyc);
        check("fh_latency", cyc, 3);
        check("fh_hit", res_hit, 1);
        check("fh_index", res_first_hit, 3);
        check("fh_count", res_count, 5);
        pop_res;
        check("fh_clr_hit", res_hit, 0);

        // All-zero batch reports no hit.
        for (int i = 0; i < 2; i++) begin
            step;
            cmd_valid = 1'b1; cmd_cfg = CFG_W'(32 + i); cmd_last = (i == 1); cur_mask = '0;
        end
        step;
        cmd_valid = 1'b0; cmd_last = 1'b0;
        wait_res(cyc);
        check("fz_latency", cyc, 3);
        check("fz_hit", res_hit, 0);
        check("fz_index", res_first_hit, 0);
        pop_res;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
